// File: rtl/sll_operand_loader.sv
// sll_operand_loader: gathers Nbits/Bbits narrow beats into one word over a
// valid/ready byte stream and hands the registered word to the <<3 shifter.
// ShiftOvf travels with each word and marks that a signed <<3 of it loses
// significance.
module sll_operand_loader #(
    parameter int Nbits     = 32,
    parameter int Bbits     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [Bbits-1:0]        InByte,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    Flush,
    output logic signed [Nbits-1:0] Out,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    ShiftOvf
);

    // Number of beats per word and the width of the beat counter.
    localparam int K  = Nbits / Bbits;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    // Width sanity. Partial beats are not supported. The overflow test needs
    // at least the four top bits.
    if ((Nbits % Bbits) != 0 || Bbits < 1) begin : g_bad_ratio
        $error("sll_operand_loader: Nbits must be an integer multiple of Bbits");
    end
    if (Nbits < 4) begin : g_bad_width
        $error("sll_operand_loader: Nbits must be at least 4");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [CW-1:0]            count;
    logic [Nbits-1:0]         shift;
    logic [Nbits-1:0]         word_next;
    logic                     accept;
    logic                     last_beat;

    // Fold one beat into the partial word. For MSB-first order, earlier beats
    // move toward the top. For LSB-first order, earlier beats move toward the
    // bottom. Shifts are used instead of slices so that K == 1 still
    // elaborates.
    function automatic logic [Nbits-1:0] fold_beat(
        input logic [Nbits-1:0] partial,
        input logic [Bbits-1:0] beat
    );
        logic [Nbits-1:0] beat_ext;
        beat_ext = Nbits'(beat);
        if (MSB_FIRST != 0)
            fold_beat = (partial << Bbits) | beat_ext;
        else
            fold_beat = (partial >> Bbits) | (beat_ext << (Nbits - Bbits));
    endfunction

    // A signed left shift by 3 keeps its value only when the four top bits
    // all match the sign bit.
    function automatic logic shl3_overflows(input logic [Nbits-1:0] w);
        logic [3:0] top;
        top = w[Nbits-1 -: 4];
        shl3_overflows = !((top == 4'b0000) || (top == 4'b1111));
    endfunction

    // The handshake is decoded only from registered state. OutReady never
    // reaches InReady combinationally.
    assign InReady   = (state == COLLECT);
    assign accept    = InValid && InReady && !Flush;
    assign last_beat = (count == CW'(K - 1));
    assign word_next = fold_beat(shift, InByte);

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= COLLECT;
        else
            state <= state_next;
    end

    // Next-state logic. A word completes on its K-th accepted beat. It leaves
    // HOLD only when the consumer takes it. Flush has no effect in HOLD.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && last_beat) state_next = HOLD;
            HOLD:    if (OutReady)            state_next = COLLECT;
            default:                          state_next = COLLECT;
        endcase
    end

    // Beat counter. Flush discards the partial word by rewinding the count.
    // Stale bits left in the shifter get pushed out by the next K beats.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (state == COLLECT) begin
            if (Flush)
                count <= '0;
            else if (accept)
                count <= last_beat ? '0 : count + CW'(1);
        end
    end

    // Assembly shift register. This is pure datapath and needs no reset,
    // because the count decides which bits are meaningful.
    always_ff @(posedge clk) begin
        if (accept)
            shift <= fold_beat(shift, InByte);
    end

    // Output word and its overflow flag. They are captured together on the
    // completing beat and held after the transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            Out      <= '0;
            ShiftOvf <= 1'b0;
        end else if (accept && last_beat) begin
            Out      <= word_next;
            ShiftOvf <= shl3_overflows(word_next);
        end
    end

    // Output valid. It rises on the completing beat and drops when the
    // consumer accepts the word.
    always_ff @(posedge clk) begin
        if (reset)
            OutValid <= 1'b0;
        else if (accept && last_beat)
            OutValid <= 1'b1;
        else if (state == HOLD && OutReady)
            OutValid <= 1'b0;
    end

endmodule
